// File: rtl/read_module_if.sv
// read_module_if: start/status, BRAM read port and pixel stream of the input stage.
interface read_module_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int PIXEL_SIZE  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] num_words;
  logic                   busy;
  logic                   done;
  logic [ADDR_WIDTH-1:0]  bram_addr;
  logic                   bram_en;
  logic [DATA_WIDTH-1:0]  bram_rdata;
  logic [PIXEL_SIZE-1:0]  pixel;
  logic                   pixel_valid;
  logic                   pixel_ready;
  modport master (
    input  start, num_words, bram_rdata, pixel_ready,
    output busy, done, bram_addr, bram_en, pixel, pixel_valid
  );
  modport slave (
    output start, num_words, bram_rdata, pixel_ready,
    input  busy, done, bram_addr, bram_en, pixel, pixel_valid
  );
endinterface

// File: rtl/read_module.sv
// read_module: fetches packed BRAM words and streams them out as pixels, most significant byte first.
module read_module #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] INPUT_ADDR     = 32'hB000_0000,
  parameter int                    PIXEL_SIZE     = 8,
  parameter int                    PIXEL_PER_WORD = 4,
  parameter int                    COUNT_WIDTH    = 16
) (
  input logic          clk,
  input logic          reset,
  read_module_if.master bus
);
  localparam int IDX_W = $clog2(PIXEL_PER_WORD);
  typedef enum logic [2:0] {IDLE, REQUEST, WAIT, STREAM, DONE} state_t;
  state_t                 state, state_next;
  logic [IDX_W-1:0]       index;
  logic [COUNT_WIDTH-1:0] words_left;
  logic [DATA_WIDTH-1:0]  word_reg;
  logic                   accept;
  assign accept          = state == STREAM && bus.pixel_ready;
  assign bus.pixel_valid = state == STREAM;
  assign bus.pixel       = state == STREAM ? word_reg[index*PIXEL_SIZE +: PIXEL_SIZE] : '0;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = bus.start ? (bus.num_words == '0 ? DONE : REQUEST) : IDLE;
      REQUEST: state_next = WAIT;
      WAIT:    state_next = STREAM;
      STREAM:  state_next = accept && index == '0 ? (words_left > 1 ? REQUEST : DONE) : STREAM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // Status outputs are registered copies of the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      index         <= IDX_W'(PIXEL_PER_WORD - 1);
      words_left    <= '0;
      word_reg      <= '0;
      bus.bram_addr <= INPUT_ADDR;
      bus.bram_en   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state       <= state_next;
      bus.bram_en <= state_next == REQUEST;
      bus.busy    <= state_next inside {REQUEST, WAIT, STREAM};
      bus.done    <= state_next == DONE;
      if (state == IDLE && bus.start) begin
        words_left    <= bus.num_words;
        bus.bram_addr <= INPUT_ADDR;
      end
      if (state == WAIT) begin
        word_reg <= bus.bram_rdata;
        index    <= IDX_W'(PIXEL_PER_WORD - 1);
      end
      if (accept) begin
        if (index != '0) index <= index - 1'b1;
        else begin
          words_left    <= words_left - 1'b1;
          bus.bram_addr <= bus.bram_addr + ADDR_WIDTH'(DATA_WIDTH / 8);
        end
      end
    end
  end
endmodule

// File: tb/tb_read_module.sv
// tb_read_module: directed checks of the read stage, including a second instance placed at the top of the address space.
module tb_read_module;
  localparam logic [31:0] BASE_A = 32'hB000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [15:0] num_words = 0;
  logic        ready = 1;
  logic        sel = 0;
  logic [31:0] mem [4];
  logic [31:0] rdata_a = 0, rdata_b = 0;
  logic [31:0] o_addr;
  logic [7:0]  o_pixel;
  logic        o_en, o_valid, o_busy, o_done;
  int checks = 0, errors = 0;
  int en_cyc[$], pix_cyc[$], done_cyc[$];
  logic [31:0] en_addr[$];
  logic [7:0]  pix[$];
  read_module_if bus_a ();
  read_module_if bus_b ();
  read_module #(.INPUT_ADDR(BASE_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  read_module #(.INPUT_ADDR(BASE_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  always #5 clk = ~clk;
  assign bus_a.start = start & !sel;
  assign bus_b.start = start & sel;
  assign bus_a.num_words = num_words;
  assign bus_b.num_words = num_words;
  assign bus_a.pixel_ready = ready;
  assign bus_b.pixel_ready = ready;
  assign bus_a.bram_rdata = rdata_a;
  assign bus_b.bram_rdata = rdata_b;
  assign o_addr  = sel ? bus_b.bram_addr : bus_a.bram_addr;
  assign o_en    = sel ? bus_b.bram_en : bus_a.bram_en;
  assign o_pixel = sel ? bus_b.pixel : bus_a.pixel;
  assign o_valid = sel ? bus_b.pixel_valid : bus_a.pixel_valid;
  assign o_busy  = sel ? bus_b.busy : bus_a.busy;
  assign o_done  = sel ? bus_b.done : bus_a.done;
  always @(posedge clk) begin
    if (bus_a.bram_en) rdata_a <= mem[2'((bus_a.bram_addr - BASE_A) >> 2)];
    if (bus_b.bram_en) rdata_b <= mem[2'((bus_b.bram_addr - BASE_B) >> 2)];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic s, input logic [15:0] n, input int extra_k,
                     input logic [7:0] stall_px, input int stall_n);
    int done_k = -1;
    int left = stall_n;
    logic stalling = 0;
    en_cyc.delete(); en_addr.delete(); pix.delete(); pix_cyc.delete(); done_cyc.delete();
    sel = s;
    @(negedge clk);
    start = 1; num_words = n; ready = 1;
    @(posedge clk);
    #1 start = 0; num_words = 16'd7;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == extra_k);
      if (left > 0 && (stalling || (o_valid && o_pixel == stall_px))) begin
        stalling = 1;
        check("stall_pix", {24'h0, o_pixel}, {24'h0, stall_px});
        check("stall_valid", {31'h0, o_valid}, 1);
        ready = 0;
        left--;
      end else ready = 1;
      if (o_en) begin en_cyc.push_back(k); en_addr.push_back(o_addr); end
      if (o_valid && ready) begin pix.push_back(o_pixel); pix_cyc.push_back(k); end
      if (o_done) begin
        done_cyc.push_back(k);
        check("done_busy", {31'h0, o_busy}, 0);
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    if (done_k < 0) check("timeout", done_cyc.size(), 1);
    start = 0; ready = 1;
  endtask
  task automatic check_run(input string tag, input int n, input logic [31:0] base, input int exp_done);
    check({tag, "_en_cnt"}, en_cyc.size(), n);
    for (int i = 0; i < n && i < en_cyc.size(); i++) begin
      check({tag, "_en_cyc"}, en_cyc[i], 1 + 6 * i);
      check({tag, "_en_addr"}, en_addr[i], base + 32'(4 * i));
    end
    check({tag, "_pix_cnt"}, pix.size(), 4 * n);
    for (int i = 0; i < 4 * n && i < pix.size(); i++)
      check({tag, "_pix"}, {24'h0, pix[i]}, (mem[i / 4] >> (8 * (3 - i % 4))) & 32'hFF);
    check({tag, "_done_cnt"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0], exp_done);
  endtask
  initial begin
    mem[0] = 32'hA1B2C3D4; mem[1] = 0; mem[2] = 0; mem[3] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr", bus_a.bram_addr, BASE_A);
    check("rst_addr_b", bus_b.bram_addr, BASE_B);
    check("rst_en", {31'h0, bus_a.bram_en}, 0);
    check("rst_pixel", {24'h0, bus_a.pixel}, 0);
    check("rst_valid", {31'h0, bus_a.pixel_valid}, 0);
    check("rst_busy", {31'h0, bus_a.busy}, 0);
    check("rst_done", {31'h0, bus_a.done}, 0);
    reset = 0;
    run(0, 1, -1, 8'h00, 0);
    check_run("single", 1, BASE_A, 7);
    if (pix_cyc.size() == 4) check("single_pix_cyc", pix_cyc[0], 3);
    mem[0] = 32'h00010203; mem[1] = 32'h04050607; mem[2] = 32'h08090A0B;
    run(0, 3, -1, 8'h00, 0);
    check_run("multi", 3, BASE_A, 19);
    mem[0] = 32'hA1B2C3D4;
    run(0, 1, -1, 8'hB2, 3);
    check_run("stall", 1, BASE_A, 10);
    if (pix_cyc.size() == 4) check("stall_c3_cyc", pix_cyc[2], 8);
    run(0, 0, -1, 8'h00, 0);
    check_run("zero", 0, BASE_A, 1);
    mem[0] = 32'h11223344; mem[1] = 32'h55667788;
    run(0, 2, 5, 8'h00, 0);
    check_run("busy_start", 2, BASE_A, 13);
    mem[0] = 32'hCAFEF00D; mem[1] = 32'h0BADBEEF;
    run(1, 2, -1, 8'h00, 0);
    check_run("wrap", 2, BASE_B, 13);
    sel = 0;
    mem[0] = 32'hA1B2C3D4;
    @(negedge clk);
    start = 1; num_words = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(negedge clk);
    check("mid_pixel", {24'h0, bus_a.pixel}, 32'hB2);
    reset = 1;
    @(negedge clk);
    check("mr_addr", bus_a.bram_addr, BASE_A);
    check("mr_en", {31'h0, bus_a.bram_en}, 0);
    check("mr_pixel", {24'h0, bus_a.pixel}, 0);
    check("mr_valid", {31'h0, bus_a.pixel_valid}, 0);
    check("mr_busy", {31'h0, bus_a.busy}, 0);
    check("mr_done", {31'h0, bus_a.done}, 0);
    reset = 0;
    @(negedge clk);
    check("mr_no_done", {31'h0, bus_a.done}, 0);
    check("mr_idle_valid", {31'h0, bus_a.pixel_valid}, 0);
    run(0, 1, -1, 8'h00, 0);
    check_run("after_rst", 1, BASE_A, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
